ib_decode_sched_ctrl: RTL and testbench
=======================================

# ib_decode_sched_ctrl

Parametrised decoding-process controller for the IB-LDPC decoder. It sequences LLR fetch, CNU pipeline, C2V parallel-to-serial transfer, VNU pipeline and V2C transfer for one frame. It adds an iteration counter with a maximum-iteration limit, early termination, stalls on IB-ROM update busy flags, and configurable quantisation and pipeline depths. It sits in the DecodingProcessControl group and drives the CNU/VNU arrays, the P2P converters and the IB-RAM write-enable chains.

## Interface
- QUAN_SIZE, 4: message bit width; also the length of each serial transfer phase in cycles.
- CNU_PIPE, 4: CNU pipeline stages; the CNU_PIPE state lasts this many cycles.
- VNU_PIPE, 2: VNU pipeline stages; the VNU_PIPE state lasts this many cycles.
- CN_FUN_NUM, 4: number of IB-CNU decomposed functions (RAM banks).
- VN_FUN_NUM, 2: number of IB-VNU decomposed functions.
- MAX_ITER, 20: iteration limit, ≥1.
- RESET_CYCLE, 100: warm-up cycles after reset before the first frame is accepted.
- sys_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- fsm_en  in  1  low forces IDLE synchronously.
- frame_valid  in  1  a new frame is ready in the LLR buffer.
- frame_ready  out  1  high in IDLE once warm-up is done; frame accepted when frame_valid && frame_ready.
- termination  in  1  syndrome satisfied; sampled in the last P2P_V cycle.
- cn_rom_busy  in  CN_FUN_NUM  IB-ROM update in progress, per CN function.
- vn_rom_busy  in  VN_FUN_NUM  IB-ROM update in progress, per VN function.
- state  out  4  current state encoding.
- iter_cnt  out  clog2(MAX_ITER+1)  iterations completed in the current frame.
- llr_fetch, cnu_rd, vnu_rd  out  1  phase enables.
- c2v_load, v2c_load  out  1  one-cycle P2P load pulses.
- cn_ram_we  out  CN_FUN_NUM  staggered IB-CNU RAM write enables.
- vn_ram_we  out  VN_FUN_NUM  staggered IB-VNU RAM write enables.
- frame_done  out  1  one-cycle pulse at end of frame.
- early_term  out  1  valid with frame_done; 1 = terminated by syndrome, 0 = MAX_ITER reached.

## Operation
- States: WARMUP(0), IDLE(1), LLR_FETCH(2), CN_WAIT(3), CNU_PIPE(4), P2P_C(5), VN_WAIT(6), VNU_PIPE(7), P2P_V(8), DONE(9).
- A single down-counter, phase_cnt, times every timed state. Its width is clog2(max(RESET_CYCLE, QUAN_SIZE, CNU_PIPE, VNU_PIPE)+1). It is loaded on state entry and the state exits when phase_cnt==1.
- WARMUP lasts RESET_CYCLE cycles, then goes to IDLE.
- IDLE → LLR_FETCH on handshake. iter_cnt←0.
- LLR_FETCH lasts QUAN_SIZE cycles, then goes to CN_WAIT.
- CN_WAIT lasts at least 1 cycle and exits when cn_rom_busy==0, going to CNU_PIPE.
- CNU_PIPE lasts CNU_PIPE cycles, then goes to P2P_C.
- P2P_C lasts QUAN_SIZE cycles, then goes to VN_WAIT.
- VN_WAIT is the same as CN_WAIT, gated on vn_rom_busy==0, and goes to VNU_PIPE.
- VNU_PIPE lasts VNU_PIPE cycles, then goes to P2P_V.
- P2P_V lasts QUAN_SIZE cycles. On its last cycle:
  - iter_cnt increments.
  - If termination, or the new iter_cnt==MAX_ITER: go to DONE.
  - Otherwise go to CN_WAIT.
- DONE lasts 1 cycle. It asserts frame_done and early_term (=termination as sampled), then goes to IDLE.
- Output decode:
  - llr_fetch=LLR_FETCH; cnu_rd=CNU_PIPE; vnu_rd=VNU_PIPE.
  - c2v_load: first cycle of P2P_C only. v2c_load: first cycle of P2P_V only.
- RAM write enables:
  - cn_ram_we[0] is registered and high during the cycles following each CNU_PIPE cycle.
  - cn_ram_we[i] = cn_ram_we[i-1] delayed one cycle.
  - The vn_ram_we chain works the same way from VNU_PIPE.
- ROM busy inputs are ignored outside the WAIT states.

## Timing
- Reset values:
  - State: state=WARMUP; phase_cnt=RESET_CYCLE; iter_cnt=0.
  - All other outputs 0, including frame_ready and both we chains.
- Reset mid-frame aborts with no frame_done pulse and restarts warm-up.
- fsm_en=0 (synchronous):
  - Goes to IDLE if warm-up is complete, else stays in WARMUP.
  - Clears iter_cnt and the we chains. No frame_done.
- Iteration period without stalls: 2·QUAN_SIZE+CNU_PIPE+VNU_PIPE+2 cycles (16 with defaults).
- Frame latency from handshake to frame_done, N iterations: QUAN_SIZE + N·period + 1.
- frame_valid held in a non-IDLE state is ignored. frame_ready drops the cycle after acceptance.
- termination asserted and MAX_ITER reached in the same cycle: early_term=1.

## Structure
- Package ib_dec_ctrl_pkg holds:
  - the state localparams;
  - clog2 width helpers;
  - MAX of the phase lengths.
- Sub-module ram_we_delay_chain is instantiated twice, with parameter N for CN_FUN_NUM/VN_FUN_NUM. It has sys_clk, rst and a synchronous clear.

## Test plan
- Reset release → frame_ready rises exactly at cycle 100. frame_valid pulsed at cycle 50 is ignored.
- Defaults, termination never asserted → 20 iterations, frame_done at handshake+4+320+1=325 cycles, early_term=0, iter_cnt=20.
- termination=1 on the last P2P_V cycle of iteration 3 → DONE next cycle, early_term=1, iter_cnt=3.
- cn_rom_busy[2] high for 7 cycles at CN_WAIT entry → CN_WAIT lasts 7 cycles, cnu_rd stays low. cn_ram_we[3] trails cn_ram_we[0] by 3 cycles.
- rst pulsed during VNU_PIPE → all outputs zero asynchronously, WARMUP restarts, no frame_done.
- QUAN_SIZE=6, CNU_PIPE=5, VNU_PIPE=3, MAX_ITER=1 → P2P phases of 6 cycles, period 22, single-iteration frame_done, early_term=0.

Source files
------------

// File: rtl/ib_dec_ctrl_pkg.sv
// Shared definitions for the IB-LDPC decoding-process controller:
// state encodings and the width helpers used to size its counters.
package ib_dec_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_WARMUP    = 4'd0,
        ST_IDLE      = 4'd1,
        ST_LLR_FETCH = 4'd2,
        ST_CN_WAIT   = 4'd3,
        ST_CNU_PIPE  = 4'd4,
        ST_P2P_C     = 4'd5,
        ST_VN_WAIT   = 4'd6,
        ST_VNU_PIPE  = 4'd7,
        ST_P2P_V     = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

    localparam int STATE_W = 4;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2w(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Longest of the timed phases, which sizes the shared phase counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ram_we_delay_chain.sv
// Staggered write-enable chain: bit 0 is the registered input and every
// further bit repeats the previous one a cycle later, one per RAM bank.
module ram_we_delay_chain #(
    parameter int N = 4
) (
    input  logic         sys_clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         in_i,
    output logic [N-1:0] we_o
);

    logic [N-1:0] we_q;

    // Shift the enable down the bank chain; a synchronous clear empties it.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q <= '0;
        end else if (clear_i) begin
            we_q <= '0;
        end else begin
            we_q[0] <= in_i;
            for (int i = 1; i < N; i++) begin
                we_q[i] <= we_q[i-1];
            end
        end
    end

    assign we_o = we_q;

endmodule

// File: rtl/ib_decode_sched_ctrl.sv
// Decoding-process controller for one IB-LDPC frame: sequences LLR fetch,
// the CNU/VNU pipelines and the serial C2V/V2C transfers, counts
// iterations and stalls while the IB-ROMs are being updated.
module ib_decode_sched_ctrl
    import ib_dec_ctrl_pkg::*;
#(
    parameter int QUAN_SIZE   = 4,
    parameter int CNU_PIPE    = 4,
    parameter int VNU_PIPE    = 2,
    parameter int CN_FUN_NUM  = 4,
    parameter int VN_FUN_NUM  = 2,
    parameter int MAX_ITER    = 20,
    parameter int RESET_CYCLE = 100
) (
    input  logic                              sys_clk_i,
    input  logic                              rst_i,
    input  logic                              fsm_en_i,
    input  logic                              frame_valid_i,
    output logic                              frame_ready_o,
    input  logic                              termination_i,
    input  logic [CN_FUN_NUM-1:0]             cn_rom_busy_i,
    input  logic [VN_FUN_NUM-1:0]             vn_rom_busy_i,
    output logic [3:0]                        state_o,
    output logic [clog2w(MAX_ITER+1)-1:0]     iter_cnt_o,
    output logic                              llr_fetch_o,
    output logic                              cnu_rd_o,
    output logic                              vnu_rd_o,
    output logic                              c2v_load_o,
    output logic                              v2c_load_o,
    output logic [CN_FUN_NUM-1:0]             cn_ram_we_o,
    output logic [VN_FUN_NUM-1:0]             vn_ram_we_o,
    output logic                              frame_done_o,
    output logic                              early_term_o
);

    localparam int IT_W  = clog2w(MAX_ITER + 1);
    localparam int CNT_W = clog2w(max4(RESET_CYCLE, QUAN_SIZE, CNU_PIPE, VNU_PIPE) + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IT_W-1:0]   iter_q, iter_d, iter_inc;
    logic              last_cycle;

    logic frame_ready_q, llr_fetch_q, cnu_rd_q, vnu_rd_q;
    logic c2v_load_q, v2c_load_q, frame_done_q, early_term_q;

    assign last_cycle = (cnt_q == CNT_W'(1));
    assign iter_inc   = iter_q + IT_W'(1);

    // Next-state logic: each timed state counts phase_cnt down to 1 and
    // reloads it with the length of the state it hands over to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        if (!fsm_en_i) begin
            if (state_q != ST_WARMUP) begin
                state_d = ST_IDLE;
            end
            iter_d = '0;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (last_cycle) state_d = ST_IDLE;
                    else            cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_IDLE: begin
                    if (frame_valid_i) begin
                        state_d = ST_LLR_FETCH;
                        cnt_d   = CNT_W'(QUAN_SIZE);
                        iter_d  = '0;
                    end
                end
                ST_LLR_FETCH: begin
                    if (last_cycle) state_d = ST_CN_WAIT;
                    else            cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_CN_WAIT: begin
                    if (cn_rom_busy_i == '0) begin
                        state_d = ST_CNU_PIPE;
                        cnt_d   = CNT_W'(CNU_PIPE);
                    end
                end
                ST_CNU_PIPE: begin
                    if (last_cycle) begin
                        state_d = ST_P2P_C;
                        cnt_d   = CNT_W'(QUAN_SIZE);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_P2P_C: begin
                    if (last_cycle) state_d = ST_VN_WAIT;
                    else            cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_VN_WAIT: begin
                    if (vn_rom_busy_i == '0) begin
                        state_d = ST_VNU_PIPE;
                        cnt_d   = CNT_W'(VNU_PIPE);
                    end
                end
                ST_VNU_PIPE: begin
                    if (last_cycle) begin
                        state_d = ST_P2P_V;
                        cnt_d   = CNT_W'(QUAN_SIZE);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_P2P_V: begin
                    if (last_cycle) begin
                        iter_d = iter_inc;
                        if (termination_i || (iter_inc == IT_W'(MAX_ITER))) state_d = ST_DONE;
                        else                                                state_d = ST_CN_WAIT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and outputs registered together, so every output is
    // aligned with the state it belongs to and is cleared at once by reset.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_WARMUP;
            cnt_q         <= CNT_W'(RESET_CYCLE);
            iter_q        <= '0;
            frame_ready_q <= 1'b0;
            llr_fetch_q   <= 1'b0;
            cnu_rd_q      <= 1'b0;
            vnu_rd_q      <= 1'b0;
            c2v_load_q    <= 1'b0;
            v2c_load_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            early_term_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            iter_q        <= iter_d;
            frame_ready_q <= (state_d == ST_IDLE);
            llr_fetch_q   <= (state_d == ST_LLR_FETCH);
            cnu_rd_q      <= (state_d == ST_CNU_PIPE);
            vnu_rd_q      <= (state_d == ST_VNU_PIPE);
            c2v_load_q    <= (state_d == ST_P2P_C) && (state_q != ST_P2P_C);
            v2c_load_q    <= (state_d == ST_P2P_V) && (state_q != ST_P2P_V);
            frame_done_q  <= (state_d == ST_DONE);
            early_term_q  <= (state_d == ST_DONE) && termination_i;
        end
    end

    ram_we_delay_chain #(.N(CN_FUN_NUM)) u_cn_we_chain (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .clear_i   (!fsm_en_i),
        .in_i      (state_q == ST_CNU_PIPE),
        .we_o      (cn_ram_we_o)
    );

    ram_we_delay_chain #(.N(VN_FUN_NUM)) u_vn_we_chain (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .clear_i   (!fsm_en_i),
        .in_i      (state_q == ST_VNU_PIPE),
        .we_o      (vn_ram_we_o)
    );

    assign state_o       = state_q;
    assign iter_cnt_o    = iter_q;
    assign frame_ready_o = frame_ready_q;
    assign llr_fetch_o   = llr_fetch_q;
    assign cnu_rd_o      = cnu_rd_q;
    assign vnu_rd_o      = vnu_rd_q;
    assign c2v_load_o    = c2v_load_q;
    assign v2c_load_o    = v2c_load_q;
    assign frame_done_o  = frame_done_q;
    assign early_term_o  = early_term_q;

endmodule

// File: tb/tb_ib_decode_sched_ctrl.sv
// Directed bench for ib_decode_sched_ctrl: a default-parameter instance
// plus a second instance with longer phases and a single-iteration limit.
module tb_ib_decode_sched_ctrl;

    logic       clk;
    logic       rst;
    logic       fsmEn;
    logic       frameValid;
    logic       termination;
    logic [3:0] cnBusy;
    logic [1:0] vnBusy;

    logic       frameReady, llrFetch, cnuRd, vnuRd, c2vLoad, v2cLoad, frameDone, earlyTerm;
    logic [3:0] state;
    logic [4:0] iterCnt;
    logic [3:0] cnWe;
    logic [1:0] vnWe;

    logic       frameValid2, termination2;
    logic [3:0] cnBusy2;
    logic [1:0] vnBusy2;
    logic       frameReady2, llrFetch2, cnuRd2, vnuRd2, c2vLoad2, v2cLoad2, frameDone2, earlyTerm2;
    logic [3:0] state2;
    logic [0:0] iterCnt2;
    logic [3:0] cnWe2;
    logic [1:0] vnWe2;

    int testsRun    = 0;
    int testsFailed = 0;

    ib_decode_sched_ctrl dut (
        .sys_clk_i     (clk),
        .rst_i         (rst),
        .fsm_en_i      (fsmEn),
        .frame_valid_i (frameValid),
        .frame_ready_o (frameReady),
        .termination_i (termination),
        .cn_rom_busy_i (cnBusy),
        .vn_rom_busy_i (vnBusy),
        .state_o       (state),
        .iter_cnt_o    (iterCnt),
        .llr_fetch_o   (llrFetch),
        .cnu_rd_o      (cnuRd),
        .vnu_rd_o      (vnuRd),
        .c2v_load_o    (c2vLoad),
        .v2c_load_o    (v2cLoad),
        .cn_ram_we_o   (cnWe),
        .vn_ram_we_o   (vnWe),
        .frame_done_o  (frameDone),
        .early_term_o  (earlyTerm)
    );

    ib_decode_sched_ctrl #(
        .QUAN_SIZE (6),
        .CNU_PIPE  (5),
        .VNU_PIPE  (3),
        .MAX_ITER  (1)
    ) dut2 (
        .sys_clk_i     (clk),
        .rst_i         (rst),
        .fsm_en_i      (fsmEn),
        .frame_valid_i (frameValid2),
        .frame_ready_o (frameReady2),
        .termination_i (termination2),
        .cn_rom_busy_i (cnBusy2),
        .vn_rom_busy_i (vnBusy2),
        .state_o       (state2),
        .iter_cnt_o    (iterCnt2),
        .llr_fetch_o   (llrFetch2),
        .cnu_rd_o      (cnuRd2),
        .vnu_rd_o      (vnuRd2),
        .c2v_load_o    (c2vLoad2),
        .v2c_load_o    (v2cLoad2),
        .cn_ram_we_o   (cnWe2),
        .vn_ram_we_o   (vnWe2),
        .frame_done_o  (frameDone2),
        .early_term_o  (earlyTerm2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic term, input logic [3:0] cnb, input logic [1:0] vnb);
        frameValid  = fv;
        termination = term;
        cnBusy      = cnb;
        vnBusy      = vnb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int waitCycles;
        int firstWe0;
        int firstWe3;
        int doneCount;
        int p2pcCycles;
        int firstC2v;

        rst          = 1'b1;
        fsmEn        = 1'b1;
        frameValid2  = 1'b0;
        termination2 = 1'b0;
        cnBusy2      = '0;
        vnBusy2      = '0;
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0);

        // Reset values while reset is held
        #2;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_ready", 32'(frameReady), 32'd0);
        checkOutput("rst_iter", 32'(iterCnt), 32'd0);
        checkOutput("rst_cnwe", 32'(cnWe), 32'd0);
        #20;
        rst = 1'b0;

        // Warm-up: 100 edges, frame_valid at cycle 50 ignored
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 49) frameValid = 1'b1;
            if (k == 50) begin
                frameValid = 1'b0;
                checkOutput("warm_ignore_valid", 32'(state), 32'd0);
            end
            if (k == 99) checkOutput("warm_ready_99", 32'(frameReady), 32'd0);
            if (k == 100) begin
                checkOutput("warm_ready_100", 32'(frameReady), 32'd1);
                checkOutput("warm_state_idle", 32'(state), 32'd1);
            end
        end

        // Full 20-iteration frame, no termination: DONE 4+320 edges after handshake
        applyStimulus(1'b1, 1'b0, 4'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0);
        checkOutput("hs_state", 32'(state), 32'd2);
        checkOutput("hs_ready_drop", 32'(frameReady), 32'd0);
        checkOutput("hs_llr_fetch", 32'(llrFetch), 32'd1);
        n = 0;
        while (!frameDone && n < 2000) begin
            tick();
            n++;
        end
        checkOutput("max_latency", 32'(n), 32'd324);
        checkOutput("max_early_term", 32'(earlyTerm), 32'd0);
        checkOutput("max_iter_cnt", 32'(iterCnt), 32'd20);
        checkOutput("max_state_done", 32'(state), 32'd9);
        tick();
        checkOutput("after_done_pulse", 32'(frameDone), 32'd0);
        checkOutput("after_done_ready", 32'(frameReady), 32'd1);

        // Termination on the last P2P_V cycle of iteration 3
        applyStimulus(1'b1, 1'b0, 4'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0);
        for (int t = 1; t <= 51; t++) begin
            tick();
            if (t == 5) checkOutput("it_cnu_rd", 32'(cnuRd), 32'd1);
            if (t == 9) checkOutput("it_c2v_load", 32'(c2vLoad), 32'd1);
            if (t == 10) checkOutput("it_c2v_once", 32'(c2vLoad), 32'd0);
            if (t == 14) checkOutput("it_vnu_rd", 32'(vnuRd), 32'd1);
            if (t == 16) checkOutput("it_v2c_load", 32'(v2cLoad), 32'd1);
            if (t == 17) checkOutput("it_v2c_once", 32'(v2cLoad), 32'd0);
            if (t == 20) checkOutput("it_iter1", 32'(iterCnt), 32'd1);
            if (t == 51) begin
                checkOutput("term_pre_state", 32'(state), 32'd8);
                checkOutput("term_pre_iter", 32'(iterCnt), 32'd2);
            end
        end
        applyStimulus(1'b0, 1'b1, 4'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0);
        checkOutput("term_done", 32'(frameDone), 32'd1);
        checkOutput("term_early", 32'(earlyTerm), 32'd1);
        checkOutput("term_iter", 32'(iterCnt), 32'd3);
        tick();
        checkOutput("term_back_idle", 32'(state), 32'd1);

        // CN ROM stall for 7 cycles, we chain stagger, then reset in VNU_PIPE
        applyStimulus(1'b1, 1'b0, 4'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0);
        waitCycles = 0;
        firstWe0   = -1;
        firstWe3   = -1;
        for (int t = 1; t <= 21; t++) begin
            tick();
            if (state == 4'd3) waitCycles++;
            if (cnWe[0] && firstWe0 < 0) firstWe0 = t;
            if (cnWe[3] && firstWe3 < 0) firstWe3 = t;
            if (t == 3) applyStimulus(1'b0, 1'b0, 4'b0100, 2'd0);
            if (t == 10) begin
                checkOutput("stall_state", 32'(state), 32'd3);
                checkOutput("stall_cnu_rd", 32'(cnuRd), 32'd0);
                applyStimulus(1'b0, 1'b0, 4'd0, 2'd0);
            end
            if (t == 11) checkOutput("stall_release", 32'(state), 32'd4);
            if (t == 21) begin
                checkOutput("vnu_state", 32'(state), 32'd7);
                checkOutput("vnu_we", 32'(vnWe), 32'd1);
            end
        end
        checkOutput("stall_cycles", 32'(waitCycles), 32'd7);
        checkOutput("cn_we0_first", 32'(firstWe0), 32'd12);
        checkOutput("cn_we3_first", 32'(firstWe3), 32'd15);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_state", 32'(state), 32'd0);
        checkOutput("arst_vnu_rd", 32'(vnuRd), 32'd0);
        checkOutput("arst_vn_we", 32'(vnWe), 32'd0);
        checkOutput("arst_iter", 32'(iterCnt), 32'd0);
        #2;
        rst = 1'b0;
        doneCount = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (frameDone) doneCount++;
            if (k == 99) checkOutput("rewarm_ready_99", 32'(frameReady), 32'd0);
            if (k == 100) checkOutput("rewarm_ready_100", 32'(frameReady), 32'd1);
        end
        checkOutput("rewarm_no_done", 32'(doneCount), 32'd0);

        // fsm_en low mid-frame forces IDLE and clears the we chains
        applyStimulus(1'b1, 1'b0, 4'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0);
        for (int t = 1; t <= 6; t++) tick();
        checkOutput("en_pre_we", 32'(cnWe), 32'd1);
        fsmEn = 1'b0;
        tick();
        checkOutput("en_idle", 32'(state), 32'd1);
        checkOutput("en_cn_we_clr", 32'(cnWe), 32'd0);
        checkOutput("en_no_done", 32'(frameDone), 32'd0);
        fsmEn = 1'b1;
        tick();
        checkOutput("en_ready", 32'(frameReady), 32'd1);

        // Second instance: QUAN 6, CNU 5, VNU 3, MAX_ITER 1 -> DONE 6+22 edges after handshake
        frameValid2 = 1'b1;
        tick();
        frameValid2 = 1'b0;
        n = 0;
        p2pcCycles = 0;
        firstC2v = -1;
        while (!frameDone2 && n < 2000) begin
            tick();
            n++;
            if (state2 == 4'd5) p2pcCycles++;
            if (c2vLoad2 && firstC2v < 0) firstC2v = n;
        end
        checkOutput("p2_latency", 32'(n), 32'd28);
        checkOutput("p2_p2pc_len", 32'(p2pcCycles), 32'd6);
        checkOutput("p2_c2v_at", 32'(firstC2v), 32'd12);
        checkOutput("p2_early", 32'(earlyTerm2), 32'd0);
        checkOutput("p2_iter", 32'(iterCnt2), 32'd1);
        tick();

        // Termination coinciding with MAX_ITER reports early termination
        frameValid2  = 1'b1;
        termination2 = 1'b1;
        tick();
        frameValid2 = 1'b0;
        n = 0;
        while (!frameDone2 && n < 2000) begin
            tick();
            n++;
        end
        termination2 = 1'b0;
        checkOutput("p2t_latency", 32'(n), 32'd28);
        checkOutput("p2t_early", 32'(earlyTerm2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
